popcount_accum: RTL

Frame accumulator that sits directly downstream of the `count_1` 4-bit popcount stage. Takes one 3-bit ones-count per accepted beat (legal range 0..4), sums `FRAME_LEN` beats into a frame total, and presents the total on a valid/ready output port. Used to derive per-frame bit-density figures from the nibble stream that feeds `count_1`.

---
 rtl/popcount_accum.sv | 131 +++++++++++++
 1 files changed

// File: rtl/popcount_accum.sv
// Frame accumulator behind the count_1 popcount stage: sums FRAME_LEN ones-counts per frame
// and holds the total on a valid/ready port. Optional threshold flag under POPACC_THRESH_EN.
module popcount_accum #(
    parameter int FRAME_LEN = 4,
    parameter int SUM_W     = 5,
    parameter int THRESH    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_count,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [SUM_W-1:0] sum,
    output logic             err
`ifdef POPACC_THRESH_EN
    ,
    output logic             above_thresh
`endif
);

    if (FRAME_LEN < 1 || FRAME_LEN > 255) begin : g_bad_frame_len
        $error("popcount_accum: FRAME_LEN out of range 1..255");
    end
    if (SUM_W < 3 || SUM_W < $clog2(4 * FRAME_LEN + 1)) begin : g_bad_sum_w
        $error("popcount_accum: SUM_W too narrow for FRAME_LEN");
    end
    if (THRESH < 0) begin : g_bad_thresh
        $error("popcount_accum: THRESH must be non-negative");
    end

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] acc_next;
    logic [7:0]       beat_cnt;
    logic             accept;
    logic             legal;
    logic             last_beat;
    logic [2:0]       add;

    // Illegal counts still occupy a beat slot but contribute nothing to the total.
    assign accept    = in_valid && in_ready && !flush;
    assign legal     = (in_count <= 3'd4);
    assign add       = legal ? in_count : 3'd0;
    assign acc_next  = acc + SUM_W'(add);
    assign last_beat = (beat_cnt == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Handshake outputs depend on state only, so sum_ready never reaches in_ready.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        sum_valid  = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && !flush && last_beat) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                sum_valid = 1'b1;
                if (sum_ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
        if (flush) begin
            state_next = ACCUM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            beat_cnt <= '0;
            sum      <= '0;
            err      <= 1'b0;
        end else begin
            if (flush) begin
                acc      <= '0;
                beat_cnt <= '0;
            end else if (accept) begin
                if (last_beat) begin
                    acc      <= '0;
                    beat_cnt <= '0;
                    sum      <= acc_next;
                end else begin
                    acc      <= acc_next;
                    beat_cnt <= beat_cnt + 8'd1;
                end
            end
            if (accept && !legal) begin
                err <= 1'b1;
            end
        end
    end

`ifdef POPACC_THRESH_EN
    localparam logic [31:0] THRESH_U = THRESH;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            above_thresh <= 1'b0;
        end else if (flush) begin
            above_thresh <= 1'b0;
        end else if (accept && last_beat) begin
            above_thresh <= (32'(acc_next) >= THRESH_U);
        end
    end
`endif

endmodule
